// File: rtl/mig_serial_adder.sv
// Bit-serial add/subtract unit built from majority and inversion only.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with a, b, sub
// (1 = a - b); out_valid/out_ready with sum, cout (no-borrow on subtract),
// ovf (signed overflow). One bit per clock, LSB first, no overlap.
module mig_serial_adder #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
    logic               carry_q, carry_d;
    logic               c_msb_q, c_msb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               c_next;
    logic               s_bit;

    // Carry cell is the plain majority; the sum bit reuses it so that the
    // whole full adder is expressed as three majority gates and inverters.
    assign c_next = maj(a_sr_q[0], b_sr_q[0], carry_q);
    assign s_bit  = maj(~c_next, carry_q, maj(a_sr_q[0], b_sr_q[0], ~carry_q));

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_sr_q;
    assign cout      = carry_q;
    assign ovf       = c_msb_q ^ carry_q;

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        c_msb_d  = c_msb_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtract as a + ~b + 1: the +1 enters as carry-in.
                    a_sr_d  = a;
                    b_sr_d  = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sum_sr_d = {s_bit, sum_sr_q[WIDTH-1:1]};
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                carry_d  = c_next;
                if (cnt_q == LAST) begin
                    // Current carry is the carry into the MSB position.
                    c_msb_d = carry_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            c_msb_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            c_msb_q  <= c_msb_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mig_serial_adder.sv
// Self-checking bench for mig_serial_adder: directed vectors with literal
// expectations plus an arithmetic reference checked every output cycle.
module tb_mig_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mig_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference from integer arithmetic: {ovf, cout, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic s);
        int ia;
        int ib;
        int r;
        logic [W-1:0] su;
        logic co;
        logic ov;
        ia = int'($signed(x));
        ib = int'($signed(y));
        r  = s ? ia - ib : ia + ib;
        ov = (r > (2**(W-1)) - 1) || (r < -(2**(W-1)));
        su = s ? x - y : x + y;
        co = s ? (x >= y) : ((int'(x) + int'(y)) >= 2**W);
        return {ov, co, su};
    endfunction

    logic [W+1:0] exp_q = '0;
    bit have_exp = 0;
    bit prev_ov = 0;
    bit ho = 0;
    int acc_edge = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            have_exp = 0;
            prev_ov  = 0;
            ho       = 0;
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
        end else begin
            if (ho) chk("ready_after_hs", 32'(in_ready), 32'd1);
            ho = 0;
            if (out_valid) begin
                if (!have_exp) begin
                    chk("spurious_out_valid", 32'(out_valid), 32'(have_exp));
                end else begin
                    if (!prev_ov) chk("latency", 32'(cyc - acc_edge), 32'(W));
                    chk("sum", 32'(sum), 32'(exp_q[W-1:0]));
                    chk("cout", 32'(cout), 32'(exp_q[W]));
                    chk("ovf", 32'(ovf), 32'(exp_q[W+1]));
                    chk("in_ready_busy", 32'(in_ready), 32'd0);
                    if (out_ready) begin
                        have_exp = 0;
                        ho = 1;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q    = model(a, b, sub);
                have_exp = 1;
                acc_edge = cyc + 1;
            end
            prev_ov = out_valid;
        end
    end

    task automatic run(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic ts, input logic [W-1:0] es,
                       input logic ec, input logic eo,
                       input int hold, input bit noisy);
        int n;
        @(posedge clk); #1;
        a = ta;
        b = tb_;
        sub = ts;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (noisy) begin
            for (int i = 0; i < 6; i++) begin
                in_valid = 1'($urandom_range(0, 1));
                a = W'($urandom);
                b = W'($urandom);
                sub = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
        end
        n = 0;
        while (!out_valid && n < 4 * W) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_timeout", 32'(out_valid), 32'd1);
        chk("lit_sum", 32'(sum), 32'(es));
        chk("lit_cout", 32'(cout), 32'(ec));
        chk("lit_ovf", 32'(ovf), 32'(eo));
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_sum", 32'(sum), 32'(es));
            chk("hold_cout", 32'(cout), 32'(ec));
            chk("hold_ovf", 32'(ovf), 32'(eo));
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_ready", 32'(in_ready), 32'd1);
        chk("idle_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, errors %0d", errors);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        chk("post_reset_out_valid", 32'(out_valid), 32'd0);
        chk("post_reset_sum", 32'(sum), 32'd0);

        run(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 0, 1'b0);
        run(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0, 1'b0);
        run(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0);
        run(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 0, 1'b0);
        run(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 0, 1'b0);
        run(8'hC3, 8'h5A, 1'b0, 8'h1D, 1'b1, 1'b0, 5, 1'b1);
        run(8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 0, 1'b0);

        @(posedge clk); #1;
        a = 8'hFF;
        b = 8'hFF;
        sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0, 1'b0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
